multi_digit_seven_segment: RTL and testbench
============================================

MULTI_DIGIT_SEVEN_SEGMENT -- requirements
Module: multi_digit_seven_segment

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4, number of multiplexed digits (1..8).
REQ-002 SHALL have parameter SCAN_DIV, default 25000, clock cycles each digit is driven (>=2).
REQ-003 SHALL have port i_Clk  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port i_Rst_L  input  1  reset; one clock; reset is synchronous and active-low.
REQ-005 SHALL have port i_Value  input  4*NUM_DIGITS  hex nibbles; nibble k is digit k, digit 0 least significant.
REQ-006 SHALL have port i_Valid  input  1  i_Value offered for update.
REQ-007 SHALL have port o_Ready  output  1  update accepted when i_Valid && o_Ready.
REQ-008 SHALL have port o_Segments  output  7  segment drive, active-high, bit0=A .. bit6=G.
REQ-009 SHALL have port o_Digit_En  output  NUM_DIGITS  one-hot digit select, active-high.
REQ-010 SHALL have port o_Frame_Start  output  1  one-cycle pulse when digit 0 is first driven in a frame.

Function
REQ-011 Decoder SHALL map nibble to o_Segments (hex): 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71.
REQ-012 Divider counter SHALL count 0..SCAN_DIV-1 and wrap; digit index SHALL advance on the terminal count, wrapping NUM_DIGITS-1 -> 0.
REQ-013 o_Digit_En, o_Segments and o_Frame_Start SHALL be registered, reflecting the digit index with exactly one cycle of latency; each digit is held for exactly SCAN_DIV cycles.
REQ-014 o_Segments SHALL always show the nibble of the display register selected by the currently asserted o_Digit_En bit.
REQ-015 On i_Valid && o_Ready, i_Value SHALL be captured into a pending register and o_Ready SHALL deassert the next cycle.
REQ-016 On the cycle the digit index wraps to 0, a pending value SHALL be copied to the display register; o_Ready SHALL reassert the next cycle (no mid-frame tearing).
REQ-017 If acceptance and index wrap occur in the same cycle, i_Value SHALL load the display register directly and o_Ready SHALL stay high.
REQ-018 i_Valid while o_Ready low SHALL be ignored; i_Value need not be held after acceptance.
REQ-019 With NUM_DIGITS=1, o_Digit_En SHALL be constant 1 after reset and o_Frame_Start SHALL pulse every SCAN_DIV cycles.

Reset
REQ-020 While i_Rst_L low at a clock edge: divider, digit index, pending and display registers SHALL clear to 0; o_Segments=0, o_Digit_En=0, o_Frame_Start=0, o_Ready=1.
REQ-021 First edge after release SHALL drive o_Digit_En=1 (digit 0), o_Segments=3F, o_Frame_Start=1.
REQ-022 Reset mid-frame or with an update pending SHALL discard the pending value and restart at digit 0.

Configuration
REQ-023 Macro LEADING_ZERO_BLANK_EN defined: digits more significant than the highest non-zero display nibble SHALL output o_Segments=00 while still scanned; digit 0 SHALL never be blanked.
REQ-024 Macro undefined: every digit SHALL be decoded per REQ-011, zeros shown as 3F.

Structure
REQ-025 Package seven_segment_pkg SHALL hold the 16-entry segment table, segment bit-index constants (SEG_A..SEG_G) and the blank pattern constant.
REQ-026 Combinational nibble decoder SHALL be sub-module hex_to_seven_segment (4-bit in, 7-bit out), instantiated once after the digit mux.

Verification (NUM_DIGITS=4, SCAN_DIV=4)
REQ-027 Reset release -> o_Digit_En=0001, o_Segments=3F, o_Frame_Start=1 one cycle; o_Digit_En 0010 after 4 cycles; frame period 16 cycles.
REQ-028 Accept i_Value=16'h12AF mid-frame -> o_Ready low until wrap; next frame shows digits 0..3 as 71,77,5B,06.
REQ-029 i_Valid with i_Value=16'h0005 exactly on wrap cycle -> o_Ready stays 1; the frame starting that edge shows 6D,3F,3F,3F (blank 6D,00,00,00 with LEADING_ZERO_BLANK_EN).
REQ-030 i_Valid pulsed while o_Ready=0 with 16'hFFFF -> ignored; displayed value is the earlier accepted one.
REQ-031 i_Rst_L low for one cycle mid-frame with update pending -> all outputs 0, o_Ready=1, then REQ-027 sequence with value 0000.
REQ-032 Sweep each nibble 0..F on digit 0 -> o_Segments matches REQ-011 table for all 16 codes.

Source files
------------

// File: rtl/seven_segment_pkg.sv
// Shared constants for the multiplexed seven-segment display:
// segment bit positions, the hex glyph table and the blank pattern.
package seven_segment_pkg;

    // Segment bit positions within the 7-bit drive word
    localparam int SEG_A = 0;
    localparam int SEG_B = 1;
    localparam int SEG_C = 2;
    localparam int SEG_D = 3;
    localparam int SEG_E = 4;
    localparam int SEG_F = 5;
    localparam int SEG_G = 6;

    localparam logic [6:0] SEG_BLANK = 7'h00;

    // Entry k is the active-high glyph for hex digit k
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'h71, 7'h79, 7'h5E, 7'h39,
        7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66,
        7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    function automatic logic [6:0] seg_decode(
        input logic [3:0] nib
    );
        return SEG_TABLE[nib];
    endfunction

endpackage

// File: rtl/hex_to_seven_segment.sv
// Combinational hex nibble to seven-segment glyph decoder.
// Ports: i_Nibble (4-bit code), o_Segments (7-bit, bit0=A..bit6=G).
module hex_to_seven_segment
    import seven_segment_pkg::*;
(
    input  logic [3:0] i_Nibble,
    output logic [6:0] o_Segments
);

    assign o_Segments = seg_decode(i_Nibble);

endmodule

// File: rtl/multi_digit_seven_segment.sv
// Time-multiplexed multi-digit seven-segment driver with a
// frame-synchronous update handshake (no mid-frame tearing).
// Ports: i_Clk, i_Rst_L (sync, active-low), i_Value/i_Valid/o_Ready
// update handshake, o_Segments, o_Digit_En (one-hot), o_Frame_Start.
// Optional: define LEADING_ZERO_BLANK_EN to blank leading zero digits.
module multi_digit_seven_segment
    import seven_segment_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 25000
) (
    input  logic                    i_Clk,
    input  logic                    i_Rst_L,
    input  logic [4*NUM_DIGITS-1:0] i_Value,
    input  logic                    i_Valid,
    output logic                    o_Ready,
    output logic [6:0]              o_Segments,
    output logic [NUM_DIGITS-1:0]   o_Digit_En,
    output logic                    o_Frame_Start
);

    localparam int IDX_W =
        (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int VAL_W = 4 * NUM_DIGITS;

    localparam logic [DIV_W-1:0] DIV_LAST =
        DIV_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST =
        IDX_W'(NUM_DIGITS - 1);

    logic [DIV_W-1:0]      r_div;
    logic [IDX_W-1:0]      r_idx;
    logic [VAL_W-1:0]      r_pending;
    logic                  r_pend_vld;
    logic [VAL_W-1:0]      r_disp;
    logic [6:0]            r_seg;
    logic [NUM_DIGITS-1:0] r_en;
    logic                  r_fs;

    logic                  w_tick;
    logic                  w_wrap;
    logic                  w_accept;
    logic [3:0]            w_nibble;
    logic [6:0]            w_seg;
    logic                  w_blank;

    assign w_tick   = (r_div == DIV_LAST);
    assign w_wrap   = w_tick && (r_idx == IDX_LAST);
    assign o_Ready  = !r_pend_vld;
    assign w_accept = i_Valid && o_Ready;

    // Digit mux: select the display nibble for the current index
    always_comb begin
        w_nibble = 4'h0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (r_idx == IDX_W'(k)) begin
                w_nibble = r_disp[4*k +: 4];
            end
        end
    end

    hex_to_seven_segment u_dec (
        .i_Nibble   (w_nibble),
        .o_Segments (w_seg)
    );

`ifdef LEADING_ZERO_BLANK_EN
    logic [IDX_W-1:0] w_top;

    // Highest non-zero digit; anything above it is a leading zero.
    // An all-zero value leaves w_top at 0 so digit 0 stays lit.
    always_comb begin
        w_top = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (r_disp[4*k +: 4] != 4'h0) begin
                w_top = IDX_W'(k);
            end
        end
    end

    assign w_blank = (r_idx > w_top);
`else
    assign w_blank = 1'b0;
`endif

    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            r_div      <= '0;
            r_idx      <= '0;
            r_pending  <= '0;
            r_pend_vld <= 1'b0;
            r_disp     <= '0;
            r_seg      <= '0;
            r_en       <= '0;
            r_fs       <= 1'b0;
        end else begin
            r_div <= w_tick ? '0 : r_div + 1'b1;

            if (w_tick) begin
                r_idx <= w_wrap ? '0 : r_idx + 1'b1;
            end

            // Display only changes at the frame boundary; an
            // offer landing exactly on the wrap bypasses pending.
            if (w_wrap) begin
                if (w_accept) begin
                    r_disp <= i_Value;
                end else if (r_pend_vld) begin
                    r_disp <= r_pending;
                end
                r_pend_vld <= 1'b0;
            end else if (w_accept) begin
                r_pending  <= i_Value;
                r_pend_vld <= 1'b1;
            end

            // Outputs trail the index by exactly one cycle
            r_seg <= w_blank ? SEG_BLANK : w_seg;
            r_en  <= NUM_DIGITS'(1) << r_idx;
            r_fs  <= (r_div == '0) && (r_idx == '0);
        end
    end

    assign o_Segments    = r_seg;
    assign o_Digit_En    = r_en;
    assign o_Frame_Start = r_fs;

endmodule

// File: tb/tb_multi_digit_seven_segment.sv
// Self-checking bench for multi_digit_seven_segment
// (NUM_DIGITS=4, SCAN_DIV=4).
module tb_multi_digit_seven_segment;

    localparam int ND = 4;
    localparam int SD = 4;

    logic        clk   = 1'b0;
    logic        rst_l = 1'b0;
    logic [15:0] value = 16'h0000;
    logic        valid = 1'b0;
    logic        ready;
    logic [6:0]  seg;
    logic [3:0]  en;
    logic        fs;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [3:0] nib;
        logic [6:0] seg;
    } vec_t;

    vec_t tbl [16];

    multi_digit_seven_segment #(
        .NUM_DIGITS (ND),
        .SCAN_DIV   (SD)
    ) dut (
        .i_Clk         (clk),
        .i_Rst_L       (rst_l),
        .i_Value       (value),
        .i_Valid       (valid),
        .o_Ready       (ready),
        .o_Segments    (seg),
        .o_Digit_En    (en),
        .o_Frame_Start (fs)
    );

    always #5 clk = ~clk;

    task automatic check(
        input string       name,
        input logic [31:0] act,
        input logic [31:0] exp
    );
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h",
                     name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Advance until a frame start is visible (bounded)
    task automatic wait_frame(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (fs !== 1'b1 && n < 40);
        check("frame_start_seen", {31'd0, fs}, 1);
    endtask

    task automatic send(input logic [15:0] v);
        value = v;
        valid = 1'b1;
        tick();
        valid = 1'b0;
        value = 16'hDEAD;
    endtask

    // Called at a frame-start sample; ends on digit 3's first cycle
    task automatic check_frame(
        input string       nm,
        input logic [27:0] exp
    );
        logic [3:0] oh;
        for (int d = 0; d < ND; d++) begin
            oh = 4'b0001 << d;
            check($sformatf("%s_en%0d", nm, d),
                  {28'd0, en}, {28'd0, oh});
            check($sformatf("%s_seg%0d", nm, d),
                  {25'd0, seg}, {25'd0, exp[7*d +: 7]});
            if (d < ND - 1) begin
                repeat (SD) tick();
            end
        end
    endtask

    logic [27:0] exp5;
    int          n;

    initial begin
        tbl[0]  = '{4'h0, 7'h3F};
        tbl[1]  = '{4'h1, 7'h06};
        tbl[2]  = '{4'h2, 7'h5B};
        tbl[3]  = '{4'h3, 7'h4F};
        tbl[4]  = '{4'h4, 7'h66};
        tbl[5]  = '{4'h5, 7'h6D};
        tbl[6]  = '{4'h6, 7'h7D};
        tbl[7]  = '{4'h7, 7'h07};
        tbl[8]  = '{4'h8, 7'h7F};
        tbl[9]  = '{4'h9, 7'h6F};
        tbl[10] = '{4'hA, 7'h77};
        tbl[11] = '{4'hB, 7'h7C};
        tbl[12] = '{4'hC, 7'h39};
        tbl[13] = '{4'hD, 7'h5E};
        tbl[14] = '{4'hE, 7'h79};
        tbl[15] = '{4'hF, 7'h71};

        // Reset state
        rst_l = 1'b0;
        tick();
        tick();
        check("rst_seg", {25'd0, seg}, 0);
        check("rst_en", {28'd0, en}, 0);
        check("rst_fs", {31'd0, fs}, 0);
        check("rst_ready", {31'd0, ready}, 1);

        // First edge after release
        rst_l = 1'b1;
        tick();
        check("rel_en", {28'd0, en}, 1);
        check("rel_seg", {25'd0, seg}, 32'h3F);
        check("rel_fs", {31'd0, fs}, 1);
        tick();
        check("rel_fs_pulse", {31'd0, fs}, 0);
        tick();
        tick();
        check("rel_en_hold", {28'd0, en}, 1);
        tick();
        check("rel_en_digit1", {28'd0, en}, 2);
        wait_frame(n);
        check("frame_period", n + 4, 16);

        // Mid-frame accept, then an ignored offer
        tick();
        send(16'h12AF);
        check("busy_after_accept", {31'd0, ready}, 0);
        tick();
        send(16'hFFFF);
        check("busy_ignored", {31'd0, ready}, 0);
        wait_frame(n);
        check("ready_after_wrap", {31'd0, ready}, 1);
        check_frame("f12AF", {7'h06, 7'h5B, 7'h77, 7'h71});
        wait_frame(n);
        check("ffff_ignored", {25'd0, seg}, 32'h71);

        // Offer exactly on the wrap edge
        repeat (14) tick();
        value = 16'h0005;
        valid = 1'b1;
        check("ready_pre_wrap", {31'd0, ready}, 1);
        tick();
        valid = 1'b0;
        value = 16'hDEAD;
        check("ready_on_wrap", {31'd0, ready}, 1);
        check("fs_before_frame", {31'd0, fs}, 0);
        tick();
        check("fs_wrap_frame", {31'd0, fs}, 1);
`ifdef LEADING_ZERO_BLANK_EN
        exp5 = {7'h00, 7'h00, 7'h00, 7'h6D};
`else
        exp5 = {7'h3F, 7'h3F, 7'h3F, 7'h6D};
`endif
        check_frame("f0005", exp5);

        // Reset mid-frame with an update pending
        wait_frame(n);
        tick();
        send(16'h4321);
        tick();
        check("pend_before_rst", {31'd0, ready}, 0);
        rst_l = 1'b0;
        tick();
        check("mid_rst_seg", {25'd0, seg}, 0);
        check("mid_rst_en", {28'd0, en}, 0);
        check("mid_rst_fs", {31'd0, fs}, 0);
        check("mid_rst_ready", {31'd0, ready}, 1);
        rst_l = 1'b1;
        tick();
        check("rerel_fs", {31'd0, fs}, 1);
        check_frame("f0000", {7'h3F, 7'h3F, 7'h3F, 7'h3F});
        wait_frame(n);
        check("rerel_period", n, 4);
        check("pend_discarded", {25'd0, seg}, 32'h3F);

        // Decoder sweep on digit 0
        for (int i = 0; i < 16; i++) begin
            tick();
            send({4{tbl[i].nib}});
            wait_frame(n);
            check($sformatf("sweep_%0h", tbl[i].nib),
                  {25'd0, seg}, {25'd0, tbl[i].seg});
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
